// File: rtl/udma_hyper_eot_router_pkg.sv
// Shared types and constants for the HyperBus end-of-transfer event router.
package udma_hyper_eot_router_pkg;

   typedef enum logic {
      HYPER_DIR_WR = 1'b0,
      HYPER_DIR_RD = 1'b1
   } hyper_dir_e;

   localparam int HYPER_EOT_TAG_DEPTH = 4;

endpackage

// File: rtl/udma_hyper_eot_router_if.sv
// Bundle of per-channel transaction, EOT, event and error signals seen by the router.
interface udma_hyper_eot_router_if #(
   parameter int NB_CH = 1,
   parameter int CNT_W = 3
);
   logic [NB_CH-1:0]       trans_valid_i;
   logic [NB_CH-1:0]       trans_rd_i;
   logic [NB_CH-1:0]       trans_ready_o;
   logic [NB_CH-1:0]       eot_i;
   logic [NB_CH-1:0]       udma_rx_evt_i;
   logic [NB_CH-1:0]       udma_tx_evt_i;
   logic [NB_CH-1:0]       evt_rd_eot_o;
   logic [NB_CH-1:0]       evt_wr_eot_o;
   logic [NB_CH*CNT_W-1:0] pending_o;
   logic [NB_CH-1:0]       err_ovf_o;
   logic [NB_CH-1:0]       err_unf_o;
   logic                   err_clr_i;

   modport master (
      output trans_valid_i, trans_rd_i, eot_i, udma_rx_evt_i, udma_tx_evt_i, err_clr_i,
      input  trans_ready_o, evt_rd_eot_o, evt_wr_eot_o, pending_o, err_ovf_o, err_unf_o
   );

   modport slave (
      input  trans_valid_i, trans_rd_i, eot_i, udma_rx_evt_i, udma_tx_evt_i, err_clr_i,
      output trans_ready_o, evt_rd_eot_o, evt_wr_eot_o, pending_o, err_ovf_o, err_unf_o
   );
endinterface

// File: rtl/udma_hyper_tag_fifo.sv
// 1-bit direction tag FIFO; pointers carry one extra wrap bit to tell full from empty.
module udma_hyper_tag_fifo
   import udma_hyper_eot_router_pkg::*;
#(
   parameter int DEPTH = HYPER_EOT_TAG_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             sys_clk_i,
   input  logic             rstn_i,
   input  logic             push,
   input  logic             pop,
   input  hyper_dir_e       din,
   output hyper_dir_e       dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   hyper_dir_e  mem [DEPTH];
   logic        do_pop;
   logic        do_push;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = CNT_W'(wptr - rptr);
   assign dout  = mem[rptr[AW-1:0]];

   // A pop on a full FIFO frees the slot the push lands in, so push is allowed then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer advance on accepted push/pop.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Tag storage write.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= HYPER_DIR_WR;
      end else if (do_push) begin
         mem[wptr[AW-1:0]] <= din;
      end
   end
endmodule

// File: rtl/udma_hyper_eot_router.sv
// Routes per-channel hyper EOT pulses to read-done / write-done events using queued
// direction tags, with a uDMA rx/tx based legacy inference when no tag is queued.
module udma_hyper_eot_router
   import udma_hyper_eot_router_pkg::*;
#(
   parameter int NB_CH = 1,
   parameter int DEPTH = HYPER_EOT_TAG_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                     sys_clk_i,
   input  logic                     rstn_i,
   udma_hyper_eot_router_if.slave   bus
);

   for (genvar c = 0; c < NB_CH; c++) begin : g_ch
      logic             fifo_full;
      logic             fifo_empty;
      logic [CNT_W-1:0] fifo_cnt;
      hyper_dir_e       tag;
      hyper_dir_e       route_dir;
      hyper_dir_e       legacy_dir;
      logic             do_pop;
      logic             do_push;
      logic             bypass;
      logic             fallback;
      logic             ovf_set;
      logic             evt_rd_q;
      logic             evt_wr_q;
      logic             ovf_q;
      logic             unf_q;

      assign do_pop   = bus.eot_i[c] & ~fifo_empty;
      assign bypass   = bus.eot_i[c] & fifo_empty & bus.trans_valid_i[c];
      assign fallback = bus.eot_i[c] & fifo_empty & ~bus.trans_valid_i[c];
      assign do_push  = bus.trans_valid_i[c] & ~bypass & (~fifo_full | do_pop);
      assign ovf_set  = bus.trans_valid_i[c] & fifo_full & ~do_pop;

      // Oldest tag wins; an empty FIFO takes the same-cycle push, else the legacy guess.
      always_comb begin
         route_dir = legacy_dir;
         if (do_pop)      route_dir = tag;
         else if (bypass) route_dir = hyper_dir_e'(bus.trans_rd_i[c]);
      end

      udma_hyper_tag_fifo #(
         .DEPTH (DEPTH),
         .CNT_W (CNT_W)
      ) u_tag_fifo (
         .sys_clk_i (sys_clk_i),
         .rstn_i    (rstn_i),
         .push      (do_push),
         .pop       (do_pop),
         .din       (hyper_dir_e'(bus.trans_rd_i[c])),
         .dout      (tag),
         .full      (fifo_full),
         .empty     (fifo_empty),
         .count     (fifo_cnt)
      );

      // Legacy direction tracks unambiguous uDMA rx/tx activity every cycle.
      always_ff @(posedge sys_clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            legacy_dir <= HYPER_DIR_WR;
         end else if ((legacy_dir == HYPER_DIR_RD) && bus.udma_tx_evt_i[c] && !bus.udma_rx_evt_i[c]) begin
            legacy_dir <= HYPER_DIR_WR;
         end else if ((legacy_dir == HYPER_DIR_WR) && bus.udma_rx_evt_i[c] && !bus.udma_tx_evt_i[c]) begin
            legacy_dir <= HYPER_DIR_RD;
         end
      end

      // Registered single-cycle done events.
      always_ff @(posedge sys_clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            evt_rd_q <= 1'b0;
            evt_wr_q <= 1'b0;
         end else begin
            evt_rd_q <= bus.eot_i[c] & (route_dir == HYPER_DIR_RD);
            evt_wr_q <= bus.eot_i[c] & (route_dir == HYPER_DIR_WR);
         end
      end

      // Sticky error flags; a new error in the clear cycle keeps the flag set.
      always_ff @(posedge sys_clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            if (ovf_set)             ovf_q <= 1'b1;
            else if (bus.err_clr_i)  ovf_q <= 1'b0;
            if (fallback)            unf_q <= 1'b1;
            else if (bus.err_clr_i)  unf_q <= 1'b0;
         end
      end

      assign bus.trans_ready_o[c]             = ~fifo_full;
      assign bus.evt_rd_eot_o[c]              = evt_rd_q;
      assign bus.evt_wr_eot_o[c]              = evt_wr_q;
      assign bus.err_ovf_o[c]                 = ovf_q;
      assign bus.err_unf_o[c]                 = unf_q;
      assign bus.pending_o[c*CNT_W +: CNT_W]  = fifo_cnt;
   end

endmodule
